// File: rtl/cs_min_search_if.sv
// cs_min_search_if: search request/result bundle between the path-metric/traceback logic and the min finder
interface cs_min_search_if #(
   parameter int NB_STATES = 8,
   parameter int METRIC_W = 7
);
   logic start;
   logic [NB_STATES*METRIC_W-1:0] pm_flat;
   logic busy;
   logic done;
   logic [METRIC_W-1:0] best_pm;
   logic [$clog2(NB_STATES)-1:0] best_idx;
   logic norm_flag;
   modport master (output start, pm_flat, input busy, done, best_pm, best_idx, norm_flag);
   modport slave (input start, pm_flat, output busy, done, best_pm, best_idx, norm_flag);
endinterface

// File: rtl/cs_min_search.sv
// cs_min_search: sequential minimum path-metric finder, one compare-select per clock
// over a snapshot of all states; ties resolve to the highest index.
module cs_min_search #(
   parameter int NB_STATES = 8,
   parameter int METRIC_W = 7,
   parameter int NORM_THR = 64
) (
   input logic clk,
   input logic rst,
   cs_min_search_if.slave bus
);
   localparam int IW = $clog2(NB_STATES);
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   state_t r_state;
   logic [NB_STATES*METRIC_W-1:0] r_snap;
   logic [IW-1:0] r_cnt;
   logic [IW-1:0] r_run_idx;
   logic [IW-1:0] r_best_idx;
   logic [METRIC_W-1:0] r_run_pm;
   logic [METRIC_W-1:0] r_best_pm;
   logic r_busy;
   logic r_done;
   logic r_norm;
   logic [METRIC_W-1:0] w_cand;
   logic [METRIC_W-1:0] w_nxt_pm;
   logic [IW-1:0] w_nxt_idx;
   logic w_take_b;
   logic w_last;
   always_comb begin
      w_cand = r_snap[r_cnt*METRIC_W +: METRIC_W];
      w_take_b = !(r_run_pm < w_cand);
      w_nxt_pm = w_take_b ? w_cand : r_run_pm;
      w_nxt_idx = w_take_b ? r_cnt : r_run_idx;
      w_last = r_cnt == IW'(NB_STATES - 1);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_snap <= '0;
         r_cnt <= '0;
         r_run_pm <= '0;
         r_run_idx <= '0;
         r_best_pm <= '0;
         r_best_idx <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_norm <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == SCAN) begin
            r_run_pm <= w_nxt_pm;
            r_run_idx <= w_nxt_idx;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
               r_state <= DONE;
               r_busy <= 1'b0;
               r_done <= 1'b1;
               r_best_pm <= w_nxt_pm;
               r_best_idx <= w_nxt_idx;
               r_norm <= int'(w_nxt_pm) >= NORM_THR;
            end
         end else if (bus.start) begin
            r_state <= SCAN;
            r_snap <= bus.pm_flat;
            r_run_pm <= bus.pm_flat[METRIC_W-1:0];
            r_run_idx <= '0;
            r_cnt <= IW'(1);
            r_busy <= 1'b1;
         end else begin
            r_state <= IDLE;
         end
      end
   end
   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.best_pm = r_best_pm;
   assign bus.best_idx = r_best_idx;
   assign bus.norm_flag = r_norm;
endmodule

// File: tb/tb_cs_min_search.sv
// tb_cs_min_search: randomized and directed scoreboard bench for cs_min_search
// against a per-search reference minimum and a cycle-count timing model.
module tb_cs_min_search;
   localparam int N = 8;
   localparam int MW = 7;
   typedef logic [N-1:0][MW-1:0] pm_t;
   typedef int vec_t [N];
   typedef struct {
      int pm;
      int idx;
      int norm;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int errs = 0;
   int checks = 0;
   exp_t sb[$];
   int rem = 0;
   bit exp_done = 1'b0;
   exp_t h;
   cs_min_search_if #(.NB_STATES(N), .METRIC_W(MW)) bus ();
   cs_min_search #(.NB_STATES(N), .METRIC_W(MW), .NORM_THR(64)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errs++;
         $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
      end
   endtask
   function automatic exp_t ref_min(input pm_t p);
      exp_t e;
      e.pm = 1 << MW;
      e.idx = 0;
      for (int i = 0; i < N; i++)
         if (int'(p[i]) <= e.pm) begin
            e.pm = int'(p[i]);
            e.idx = i;
         end
      e.norm = (e.pm >= 64) ? 1 : 0;
      return e;
   endfunction
   // Reference timing: a search occupies N-1 edges after capture, then one free DONE cycle
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rem = 0;
         exp_done = 1'b0;
      end else begin
         exp_done = 1'b0;
         if (rem > 0) begin
            rem--;
            exp_done = (rem == 0);
         end else if (bus.start === 1'b1) begin
            sb.push_back(ref_min(pm_t'(bus.pm_flat)));
            rem = N - 1;
         end
      end
   end
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         sb.delete();
         h = '{0, 0, 0};
      end else begin
         #1;
         if (!rst) begin
            chk("busy", int'(bus.busy), (rem > 0) ? 1 : 0);
            chk("done", int'(bus.done), int'(exp_done));
            if (bus.done === 1'b1) begin
               if (sb.size() == 0) chk("done_without_request", 1, 0);
               else h = sb.pop_front();
            end
            chk("best_pm", int'(bus.best_pm), h.pm);
            chk("best_idx", int'(bus.best_idx), h.idx);
            chk("norm_flag", int'(bus.norm_flag), h.norm);
         end
      end
   end
   function automatic pm_t mk(input vec_t v);
      pm_t p;
      for (int i = 0; i < N; i++) p[i] = MW'(v[i]);
      return p;
   endfunction
   task automatic run_known(input string nm, input vec_t v, input int epm, input int eidx,
                            input int enorm, input bit scramble);
      @(negedge clk);
      bus.pm_flat = mk(v);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      if (scramble) begin
         bus.pm_flat = '0;
         repeat (2) @(negedge clk);
         bus.start = 1'b1;
         @(negedge clk);
         bus.start = 1'b0;
      end
      repeat (10) @(negedge clk);
      chk({nm, "_pm"}, int'(bus.best_pm), epm);
      chk({nm, "_idx"}, int'(bus.best_idx), eidx);
      chk({nm, "_norm"}, int'(bus.norm_flag), enorm);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "bench did not terminate");
   end
   initial begin
      bus.start = 1'b0;
      bus.pm_flat = '0;
      #3;
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_pm", int'(bus.best_pm), 0);
      chk("rst_idx", int'(bus.best_idx), 0);
      chk("rst_norm", int'(bus.norm_flag), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      run_known("tie", '{10, 5, 7, 5, 20, 30, 127, 6}, 5, 3, 0, 1'b0);
      run_known("eq42", '{42, 42, 42, 42, 42, 42, 42, 42}, 42, 7, 0, 1'b0);
      run_known("eq100", '{100, 100, 100, 100, 100, 100, 100, 100}, 100, 7, 1, 1'b0);
      run_known("min0", '{0, 1, 1, 1, 1, 1, 1, 1}, 0, 0, 0, 1'b0);
      run_known("eq127", '{127, 127, 127, 127, 127, 127, 127, 127}, 127, 7, 1, 1'b0);
      run_known("thr64", '{70, 64, 90, 65, 64, 99, 80, 66}, 64, 4, 1, 1'b0);
      run_known("snap", '{9, 8, 3, 12, 3, 50, 4, 11}, 3, 4, 0, 1'b1);
      // Back-to-back: start held so each DONE cycle recaptures
      @(negedge clk);
      bus.pm_flat = mk('{20, 30, 15, 40, 50, 60, 70, 80});
      bus.start = 1'b1;
      repeat (8) @(negedge clk);
      bus.pm_flat = mk('{90, 80, 70, 66, 100, 110, 120, 125});
      repeat (8) @(negedge clk);
      bus.pm_flat = mk('{33, 22, 11, 44, 11, 55, 66, 77});
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      chk("b2b_pm", int'(bus.best_pm), 11);
      chk("b2b_idx", int'(bus.best_idx), 4);
      // Asynchronous reset in the 4th SCAN cycle
      @(negedge clk);
      bus.pm_flat = mk('{1, 2, 3, 4, 5, 6, 7, 8});
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_busy", int'(bus.busy), 0);
      chk("arst_done", int'(bus.done), 0);
      chk("arst_pm", int'(bus.best_pm), 0);
      chk("arst_idx", int'(bus.best_idx), 0);
      @(negedge clk);
      rst = 1'b0;
      run_known("post_rst", '{12, 9, 30, 9, 40, 50, 60, 70}, 9, 3, 0, 1'b0);
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         bus.start = ($urandom_range(0, 2) == 0);
         for (int i = 0; i < N; i++)
            bus.pm_flat[i*MW +: MW] = (c % 3 == 0) ? MW'($urandom_range(0, 3)) : MW'($urandom_range(0, 127));
      end
      bus.start = 1'b0;
      repeat (12) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
